collider_arbiter: RTL and testbench
===================================

Name: collider_arbiter

Overview:
- Shares the single combinational level collider between the two player controllers (Fireboy = requester 0, Icegirl = requester 1).
- Each player raises a request with its position. The arbiter grants round-robin, snapshots the position, and drives it onto the collider inputs.
- After a settle window it latches the returned X/Y boundaries into that player's result registers and acks.
- Sits between the player motion modules and the collider instance in the top level.

Parameters:
- COORD_W, 32, signed coordinate width (matches integer collider ports)
- SETTLE_CYC, 1, cycles collider inputs are held before capture (1..15)
- DEF_X_MIN, 0, reset/default X min bound
- DEF_X_MAX, 639, reset/default X max bound
- DEF_Y_MIN, 0, reset/default Y min bound
- DEF_Y_MAX, 479, reset/default Y max bound

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- req  in  2  per-player service request, level
- pos_x0, pos_y0  in  COORD_W each  player 0 position
- pos_x1, pos_y1  in  COORD_W each  player 1 position
- col_x_pos, col_y_pos  out  COORD_W each  position driven to collider
- col_x_min, col_x_max, col_y_min, col_y_max  in  COORD_W each  collider results
- ack  out  2  one-cycle done pulse per player
- grant  out  2  one-hot, player currently being serviced
- busy  out  1  high in DRIVE
- bnd0_x_min, bnd0_x_max, bnd0_y_min, bnd0_y_max  out  COORD_W each  latched bounds, player 0
- bnd1_x_min, bnd1_x_max, bnd1_y_min, bnd1_y_max  out  COORD_W each  latched bounds, player 1
- bnd_valid  out  2  player bounds captured at least once since reset

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high, and has priority over all other activity.
- Reset values:
  - state = IDLE; ack, grant, busy, bnd_valid = 0.
  - last_grant = 1, so player 0 wins the first tie.
  - Held position = 0, 0; col_x_pos and col_y_pos = 0.
  - All bnd* registers = DEF_* values.
- States:
  - IDLE: not servicing.
  - DRIVE: holding a snapshot on the collider, counting down settle cycles.
- Eligibility: in IDLE, elig[g] = req[g] & ~ack[g]. A request is ignored in the cycle its own ack is high.
- IDLE transitions:
  - No eligible requester: stay in IDLE.
  - Exactly one eligible: grant it.
  - Both eligible: grant ~last_grant.
- On a grant edge:
  - Snapshot that player's pos_x/pos_y into the held-position registers.
  - grant <= onehot(g), last_grant <= g, cnt <= SETTLE_CYC-1, state <= DRIVE.
- col_x_pos/col_y_pos are always driven from the held registers (registered). They are stable for the whole DRIVE window and keep the last value in IDLE.
- DRIVE, cnt != 0: cnt decrements each cycle.
- DRIVE, cnt == 0, on the edge:
  - Latch the four collider results into bnd{g}_*.
  - bnd_valid[g] <= 1, ack[g] <= 1 for exactly one cycle.
  - grant <= 0, state <= IDLE.
- busy = (state == DRIVE).
- Latency: req sampled high in IDLE at cycle 0 -> ack and new bounds visible in cycle 1+SETTLE_CYC. This is cycle 2 for the default.
- Throughput: continuous requests from both players are serviced alternately, one service every 1+SETTLE_CYC cycles, with no idle gap. The IDLE cycle coincides with the previous ack.
- Request dropped mid-DRIVE: the service completes anyway; bounds are latched and ack pulses.
- Position changes during DRIVE: ignored, because the snapshot is used.
- Non-granted player: its bnd registers are untouched and hold their values indefinitely.
- Reset during DRIVE: aborts with no capture and no ack. All outputs return to reset values on the next edge.
- Arithmetic: no arithmetic on coordinates. cnt is a 4-bit unsigned down-counter.

Decomposition:
- Shared package collider_pkg:
  - typedef coord_t (signed COORD_W).
  - Struct bounds_t {x_min, x_max, y_min, y_max}.
  - Enum arb_state_e {IDLE, DRIVE}.
  - DEF_* screen constants.
- Sub-module rr_pick2: combinational two-requester round-robin picker.
  - Inputs: elig[1:0], last_grant.
  - Outputs: valid, idx.
- The collider itself stays external, instantiated in the top level.

Test Plan:
- Reset check: hold Reset 3 cycles -> bnd0/1 = {0,639,0,479}, bnd_valid = 00, ack = 00, col_x_pos = col_y_pos = 0.
- Single request, real collider attached: req = 01 with pos0 = (100,420) -> ack = 01 exactly in cycle 2; bnd0 = {0,575,415,479}; bnd1 unchanged; bnd_valid = 01.
- Contention: req = 11 continuously, pos0 = (100,300), pos1 = (250,390):
  - acks alternate 01, 10, 01… every 2 cycles.
  - bnd0 = {0,639,255,335}.
  - bnd1 = {0,575,383,479}.
- Snapshot and drop: grant player 1 with pos1 = (100,420). During DRIVE change pos1 to (100,300) and drop req.
  - ack[1] still pulses.
  - bnd1 = {0,575,415,479}.
  - col_x_pos stays 100 throughout DRIVE.
- Reset mid-DRIVE: assert Reset in the DRIVE cycle -> no ack; bnd registers back to defaults; state IDLE next cycle.
- SETTLE_CYC = 3 build:
  - Single request -> ack in cycle 4.
  - busy high for exactly 3 cycles.
  - Collider inputs constant during that window.

Source files
------------

// File: rtl/collider_pkg.sv
// Shared types and screen defaults for the collider arbiter slice.
package collider_pkg;

  localparam int COORD_W = 32;

  typedef logic signed [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t x_min;
    coord_t x_max;
    coord_t y_min;
    coord_t y_max;
  } bounds_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } arb_state_e;

  localparam int DEF_X_MIN = 0;
  localparam int DEF_X_MAX = 639;
  localparam int DEF_Y_MIN = 0;
  localparam int DEF_Y_MAX = 479;

endpackage

// File: rtl/collider_arbiter_rr_pick2.sv
// Two-requester round-robin picker: on a tie the player not served last wins.
module rr_pick2 (
  input  logic [1:0] elig,
  input  logic       last_grant,
  output logic       valid,
  output logic       idx
);

  always_comb begin
    valid = |elig;
    idx   = elig[1];
    if (&elig) idx = ~last_grant;
  end

endmodule

// File: rtl/collider_arbiter.sv
// Time-shares one combinational level collider between the two players and
// latches each player's returned bounds after a settle window.
module collider_arbiter
  import collider_pkg::*;
#(
  parameter int COORD_W    = collider_pkg::COORD_W,
  parameter int SETTLE_CYC = 1,
  parameter int DEF_X_MIN  = collider_pkg::DEF_X_MIN,
  parameter int DEF_X_MAX  = collider_pkg::DEF_X_MAX,
  parameter int DEF_Y_MIN  = collider_pkg::DEF_Y_MIN,
  parameter int DEF_Y_MAX  = collider_pkg::DEF_Y_MAX
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [1:0]                req,
  input  logic signed [COORD_W-1:0] pos_x0,
  input  logic signed [COORD_W-1:0] pos_y0,
  input  logic signed [COORD_W-1:0] pos_x1,
  input  logic signed [COORD_W-1:0] pos_y1,
  output logic signed [COORD_W-1:0] col_x_pos,
  output logic signed [COORD_W-1:0] col_y_pos,
  input  logic signed [COORD_W-1:0] col_x_min,
  input  logic signed [COORD_W-1:0] col_x_max,
  input  logic signed [COORD_W-1:0] col_y_min,
  input  logic signed [COORD_W-1:0] col_y_max,
  output logic [1:0]                ack,
  output logic [1:0]                grant,
  output logic                      busy,
  output logic signed [COORD_W-1:0] bnd0_x_min,
  output logic signed [COORD_W-1:0] bnd0_x_max,
  output logic signed [COORD_W-1:0] bnd0_y_min,
  output logic signed [COORD_W-1:0] bnd0_y_max,
  output logic signed [COORD_W-1:0] bnd1_x_min,
  output logic signed [COORD_W-1:0] bnd1_x_max,
  output logic signed [COORD_W-1:0] bnd1_y_min,
  output logic signed [COORD_W-1:0] bnd1_y_max,
  output logic [1:0]                bnd_valid
);

  arb_state_e                state;
  logic                      last_grant;
  logic [3:0]                cnt;
  logic signed [COORD_W-1:0] hold_x, hold_y;
  logic [1:0]                elig;
  logic                      pick_valid, pick_idx;

  // A player is masked in its own ack cycle so a held request is not re-served back to back.
  assign elig = req & ~ack;

  rr_pick2 u_pick (
    .elig       (elig),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .idx        (pick_idx)
  );

  assign busy      = (state == DRIVE);
  assign col_x_pos = hold_x;
  assign col_y_pos = hold_y;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cnt        <= '0;
      hold_x     <= '0;
      hold_y     <= '0;
      ack        <= '0;
      grant      <= '0;
      bnd_valid  <= '0;
      bnd0_x_min <= COORD_W'(DEF_X_MIN);
      bnd0_x_max <= COORD_W'(DEF_X_MAX);
      bnd0_y_min <= COORD_W'(DEF_Y_MIN);
      bnd0_y_max <= COORD_W'(DEF_Y_MAX);
      bnd1_x_min <= COORD_W'(DEF_X_MIN);
      bnd1_x_max <= COORD_W'(DEF_X_MAX);
      bnd1_y_min <= COORD_W'(DEF_Y_MIN);
      bnd1_y_max <= COORD_W'(DEF_Y_MAX);
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            hold_x     <= pick_idx ? pos_x1 : pos_x0;
            hold_y     <= pick_idx ? pos_y1 : pos_y0;
            grant      <= pick_idx ? 2'b10 : 2'b01;
            last_grant <= pick_idx;
            cnt        <= 4'(SETTLE_CYC - 1);
            state      <= DRIVE;
          end
        end
        DRIVE: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (last_grant) begin
              bnd1_x_min <= col_x_min;
              bnd1_x_max <= col_x_max;
              bnd1_y_min <= col_y_min;
              bnd1_y_max <= col_y_max;
            end else begin
              bnd0_x_min <= col_x_min;
              bnd0_x_max <= col_x_max;
              bnd0_y_min <= col_y_min;
              bnd0_y_max <= col_y_max;
            end
            ack[last_grant]       <= 1'b1;
            bnd_valid[last_grant] <= 1'b1;
            grant                 <= '0;
            state                 <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_collider_arbiter.sv
// Randomized scoreboard bench: two arbiters (settle 1 and 3) share stimulus,
// each against a transaction-level model and a behavioural stand-in collider.
module tb_collider_arbiter;
  import collider_pkg::*;

  typedef struct {
    bit      pl;
    coord_t  x;
    coord_t  y;
    bounds_t b;
  } exp_t;

  logic       Clk;
  logic       Reset;
  logic [1:0] req;
  coord_t     pos_x0, pos_y0, pos_x1, pos_y1;

  int n_checks = 0;
  int n_fail   = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Stand-in level collider: any fixed function of the position will do.
  function automatic bounds_t coll(coord_t x, coord_t y);
    bounds_t b;
    b.x_min = x >>> 3;
    b.x_max = x + 32'sd64;
    b.y_min = y - 32'sd15;
    b.y_max = y ^ 32'sh155;
    return b;
  endfunction

  function automatic bounds_t defaults();
    bounds_t b;
    b.x_min = DEF_X_MIN;
    b.x_max = DEF_X_MAX;
    b.y_min = DEF_Y_MIN;
    b.y_max = DEF_Y_MAX;
    return b;
  endfunction

  task automatic chk(input int k, input string nm, input logic [127:0] act, input logic [127:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL inst%0d %s: got %h expected %h at %0t", k, nm, act, expv, $time);
    end
  endtask

  for (genvar k = 0; k < 2; k++) begin : g_inst
    localparam int S = (k == 0) ? 1 : 3;

    coord_t     col_x_pos, col_y_pos;
    coord_t     b0_xn, b0_xx, b0_yn, b0_yx, b1_xn, b1_xx, b1_yn, b1_yx;
    logic [1:0] ack, grant, bnd_valid;
    logic       busy;
    bounds_t    cb;

    assign cb = coll(col_x_pos, col_y_pos);

    collider_arbiter #(.SETTLE_CYC(S)) dut (
      .Clk(Clk), .Reset(Reset), .req(req),
      .pos_x0(pos_x0), .pos_y0(pos_y0), .pos_x1(pos_x1), .pos_y1(pos_y1),
      .col_x_pos(col_x_pos), .col_y_pos(col_y_pos),
      .col_x_min(cb.x_min), .col_x_max(cb.x_max), .col_y_min(cb.y_min), .col_y_max(cb.y_max),
      .ack(ack), .grant(grant), .busy(busy),
      .bnd0_x_min(b0_xn), .bnd0_x_max(b0_xx), .bnd0_y_min(b0_yn), .bnd0_y_max(b0_yx),
      .bnd1_x_min(b1_xn), .bnd1_x_max(b1_xx), .bnd1_y_min(b1_yn), .bnd1_y_max(b1_yx),
      .bnd_valid(bnd_valid)
    );

    // Transaction model: a service occupies S cycles after the grant edge,
    // then acks; ties go to whoever was not served last.
    exp_t       q[$];
    bit         m_rst, m_busy, m_pl, m_last;
    int         m_rem;
    logic [1:0] m_ack, m_grant, m_elig;
    coord_t     m_hx, m_hy;

    always @(posedge Clk) begin
      m_rst = Reset;
      if (Reset) begin
        m_busy = 0; m_last = 1; m_rem = 0;
        m_ack = '0; m_grant = '0; m_hx = '0; m_hy = '0;
        q.delete();
      end else if (m_busy) begin
        m_ack = '0;
        if (m_rem == 0) begin
          m_ack[m_pl] = 1'b1;
          m_busy      = 0;
          m_grant     = '0;
        end else begin
          m_rem--;
        end
      end else begin
        m_elig = req & ~m_ack;
        m_ack  = '0;
        if (m_elig != 2'b00) begin
          if (m_elig == 2'b11) m_pl = !m_last;
          else                 m_pl = (m_elig == 2'b10);
          m_last  = m_pl;
          m_busy  = 1;
          m_rem   = S - 1;
          m_grant = m_pl ? 2'b10 : 2'b01;
          m_hx    = m_pl ? pos_x1 : pos_x0;
          m_hy    = m_pl ? pos_y1 : pos_y0;
          q.push_back('{pl: m_pl, x: m_hx, y: m_hy, b: coll(m_hx, m_hy)});
        end
      end
    end

    // Monitor: pops on each predicted ack and compares every output.
    bounds_t    sh0, sh1;
    logic [1:0] sh_v;
    exp_t       e;

    always @(negedge Clk) begin
      if (m_rst) begin
        sh0 = defaults(); sh1 = defaults(); sh_v = '0;
      end
      if (m_ack != 2'b00) begin
        if (q.size() == 0) begin
          chk(k, "ack_without_txn", 128'(q.size()), 128'd1);
        end else begin
          e = q.pop_front();
          if (e.pl) sh1 = e.b; else sh0 = e.b;
          sh_v[e.pl] = 1'b1;
        end
      end
      chk(k, "ack", 128'(ack), 128'(m_ack));
      chk(k, "busy", 128'(busy), 128'(m_busy));
      chk(k, "grant", 128'(grant), 128'(m_grant));
      chk(k, "col_x_pos", 128'(col_x_pos), 128'(m_hx));
      chk(k, "col_y_pos", 128'(col_y_pos), 128'(m_hy));
      if (m_busy && q.size() != 0)
        chk(k, "col_pos_snapshot", 128'({col_x_pos, col_y_pos}), 128'({q[0].x, q[0].y}));
      chk(k, "bnd_valid", 128'(bnd_valid), 128'(sh_v));
      chk(k, "bnd0", {b0_xn, b0_xx, b0_yn, b0_yx}, sh0);
      chk(k, "bnd1", {b1_xn, b1_xx, b1_yn, b1_yx}, sh1);
    end
  end

  task automatic step(input logic [1:0] r, input bit rst, input bit new_pos);
    @(posedge Clk);
    #1;
    Reset = rst;
    req   = r;
    if (new_pos) begin
      pos_x0 = $signed($urandom_range(0, 2000)) - 500;
      pos_y0 = $signed($urandom_range(0, 2000)) - 500;
      pos_x1 = $signed($urandom_range(0, 2000)) - 500;
      pos_y1 = $signed($urandom_range(0, 2000)) - 500;
    end
  endtask

  initial begin
    Reset = 1'b1; req = '0;
    pos_x0 = 100; pos_y0 = 420; pos_x1 = 250; pos_y1 = 390;
    repeat (3) step(2'b00, 1'b1, 1'b0);
    // Single player 0 request, then single player 1 with a moving position.
    step(2'b01, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0);
    repeat (4) step(2'b00, 1'b0, 1'b0);
    step(2'b10, 1'b0, 1'b0);
    repeat (3) step(2'b00, 1'b0, 1'b1);
    repeat (4) step(2'b00, 1'b0, 1'b0);
    // Sustained contention: services must alternate with no idle gap.
    repeat (60) step(2'b11, 1'b0, 1'b1);
    // Reset landing inside a service window.
    step(2'b01, 1'b0, 1'b1);
    step(2'b01, 1'b1, 1'b0);
    repeat (3) step(2'b00, 1'b0, 1'b0);
    // Random requests, drops, position churn and occasional resets.
    for (int i = 0; i < 500; i++)
      step(2'($urandom_range(0, 3)), ($urandom_range(0, 59) == 0), ($urandom_range(0, 1) == 1));
    repeat (60) step(2'b11, 1'b0, 1'b1);
    repeat (10) step(2'b00, 1'b0, 1'b0);
    @(negedge Clk);
    chk(0, "drain", 128'(g_inst[0].q.size()), 128'd0);
    chk(1, "drain", 128'(g_inst[1].q.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
